lc3_control_fsm: RTL and testbench

Microsequencer for the LC-3 datapath: drives every load-enable, bus gate and mux select, and owns the branch-enable (BEN) register. It consumes the N/Z/P outputs of the condition-code register and produces the `ld_cc` that loads it. It paces memory accesses through a `mem_ready` handshake. It implements the fetch/decode/execute sequence for the base integer, branch and load/store subset.

---
 rtl/lc3_control_fsm_pkg.sv | 58 +++++
 rtl/lc3_control_fsm_if.sv | 25 ++
 rtl/lc3_control_fsm_decode.sv | 75 +++++++
 rtl/lc3_control_fsm.sv | 69 ++++++
 tb/tb_lc3_control_fsm.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/lc3_control_fsm_pkg.sv
// lc3_pkg: state, opcode and mux encodings plus the control word shared by the LC-3 sequencer.
package lc3_pkg;
  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_ALU, S_BR, S_BR_TAKE, S_JMP,
    S_LEA, S_ADDR, S_MEM_RD, S_LD_WB, S_ST_MDR, S_MEM_WR, S_HALT
  } state_e;
  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE;
  localparam logic [1:0] PCMUX_INC   = 2'd0;
  localparam logic [1:0] PCMUX_BUS   = 2'd1;
  localparam logic [1:0] PCMUX_ADDER = 2'd2;
  localparam logic [1:0] A2_ZERO     = 2'd0;
  localparam logic [1:0] A2_OFF6     = 2'd1;
  localparam logic [1:0] A2_PCOFF9   = 2'd2;
  localparam logic [1:0] A2_PCOFF11  = 2'd3;
  localparam logic [1:0] ALU_ADD     = 2'd0;
  localparam logic [1:0] ALU_AND     = 2'd1;
  localparam logic [1:0] ALU_NOT     = 2'd2;
  localparam logic [1:0] ALU_PASSA   = 2'd3;
  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_reg;
    logic       ld_cc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       sr1mux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       r_w;
    logic       halted;
  } ctrl_t;
  function automatic state_e dispatch(input logic [3:0] op);
    case (op)
      OP_ADD, OP_AND, OP_NOT:        return S_ALU;
      OP_BR:                         return S_BR;
      OP_JMP:                        return S_JMP;
      OP_LEA:                        return S_LEA;
      OP_LD, OP_LDR, OP_ST, OP_STR:  return S_ADDR;
      default:                       return S_HALT;
    endcase
  endfunction
endpackage

// File: rtl/lc3_control_fsm_if.sv
// lc3_control_fsm_if: instruction/condition inputs and datapath control outputs of the sequencer.
interface lc3_control_fsm_if;
  logic [15:0] ir;
  logic        n, z, p, mem_ready;
  logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
  logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0]  pcmux;
  logic        addr1mux;
  logic [1:0]  addr2mux;
  logic        sr1mux;
  logic [1:0]  aluk;
  logic        mio_en, r_w, ben, halted;
  modport master (
    input  ir, n, z, p, mem_ready,
    output ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc,
           gate_pc, gate_mdr, gate_alu, gate_marmux,
           pcmux, addr1mux, addr2mux, sr1mux, aluk, mio_en, r_w, ben, halted
  );
  modport slave (
    output ir, n, z, p, mem_ready,
    input  ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc,
           gate_pc, gate_mdr, gate_alu, gate_marmux,
           pcmux, addr1mux, addr2mux, sr1mux, aluk, mio_en, r_w, ben, halted
  );
endinterface

// File: rtl/lc3_control_fsm_decode.sv
// lc3_ctrl_decode: combinational state + opcode to control word.
module lc3_ctrl_decode
  import lc3_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] op,
  output ctrl_t      ctrl
);
  logic base;
  assign base = (op == OP_LDR) || (op == OP_STR);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH1: begin
        ctrl.gate_pc = 1'b1;
        ctrl.ld_mar  = 1'b1;
        ctrl.ld_pc   = 1'b1;
        ctrl.pcmux   = PCMUX_INC;
      end
      S_FETCH2, S_MEM_RD: begin
        ctrl.mio_en = 1'b1;
        ctrl.ld_mdr = 1'b1;
      end
      S_FETCH3: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_ir    = 1'b1;
      end
      S_ALU: begin
        ctrl.gate_alu = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
        ctrl.aluk     = op == OP_AND ? ALU_AND : op == OP_NOT ? ALU_NOT : ALU_ADD;
      end
      S_BR_TAKE: begin
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.addr2mux = A2_PCOFF9;
        ctrl.ld_pc    = 1'b1;
      end
      S_JMP: begin
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.addr1mux = 1'b1;
        ctrl.addr2mux = A2_ZERO;
        ctrl.ld_pc    = 1'b1;
      end
      S_LEA: begin
        ctrl.gate_marmux = 1'b1;
        ctrl.addr2mux    = A2_PCOFF9;
        ctrl.ld_reg      = 1'b1;
      end
      S_ADDR: begin
        ctrl.gate_marmux = 1'b1;
        ctrl.ld_mar      = 1'b1;
        ctrl.addr1mux    = base;
        ctrl.addr2mux    = base ? A2_OFF6 : A2_PCOFF9;
      end
      S_LD_WB: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
      end
      S_ST_MDR: begin
        ctrl.sr1mux   = 1'b1;
        ctrl.aluk     = ALU_PASSA;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_mdr   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mio_en = 1'b1;
        ctrl.r_w    = 1'b1;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: LC-3 microsequencer holding state and BEN, driving datapath controls.
module lc3_control_fsm
  import lc3_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  lc3_control_fsm_if.master  bus
);
  state_e     state_q, state_d;
  logic       ben_q, ben_d;
  logic [3:0] op;
  ctrl_t      ctrl, ctrl_g;
  assign op = bus.ir[15:12];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH1;
      ben_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ben_q   <= ben_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ben_d   = ben_q;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = bus.mem_ready ? S_FETCH3 : S_FETCH2;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        ben_d   = (bus.ir[11] & bus.n) | (bus.ir[10] & bus.z) | (bus.ir[9] & bus.p);
        state_d = dispatch(op);
      end
      S_BR:     state_d = ben_q ? S_BR_TAKE : S_FETCH1;
      S_ADDR:   state_d = (op == OP_ST || op == OP_STR) ? S_ST_MDR : S_MEM_RD;
      S_MEM_RD: state_d = bus.mem_ready ? S_LD_WB : S_MEM_RD;
      S_ST_MDR: state_d = S_MEM_WR;
      S_MEM_WR: state_d = bus.mem_ready ? S_FETCH1 : S_MEM_WR;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH1;
    endcase
  end
  lc3_ctrl_decode u_decode (
    .state (state_q),
    .op    (op),
    .ctrl  (ctrl)
  );
  // controls are forced low combinationally while reset is held, even in FETCH1
  assign ctrl_g          = reset ? ctrl : '0;
  assign bus.ld_mar      = ctrl_g.ld_mar;
  assign bus.ld_mdr      = ctrl_g.ld_mdr;
  assign bus.ld_ir       = ctrl_g.ld_ir;
  assign bus.ld_pc       = ctrl_g.ld_pc;
  assign bus.ld_reg      = ctrl_g.ld_reg;
  assign bus.ld_cc       = ctrl_g.ld_cc;
  assign bus.gate_pc     = ctrl_g.gate_pc;
  assign bus.gate_mdr    = ctrl_g.gate_mdr;
  assign bus.gate_alu    = ctrl_g.gate_alu;
  assign bus.gate_marmux = ctrl_g.gate_marmux;
  assign bus.pcmux       = ctrl_g.pcmux;
  assign bus.addr1mux    = ctrl_g.addr1mux;
  assign bus.addr2mux    = ctrl_g.addr2mux;
  assign bus.sr1mux      = ctrl_g.sr1mux;
  assign bus.aluk        = ctrl_g.aluk;
  assign bus.mio_en      = ctrl_g.mio_en;
  assign bus.r_w         = ctrl_g.r_w;
  assign bus.halted      = ctrl_g.halted;
  assign bus.ben         = reset & ben_q;
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: per-cycle trace model of LC-3 instruction execution versus the sequencer.
module tb_lc3_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  lc3_control_fsm_if bus ();
  lc3_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       sr1mux;
    logic [1:0] aluk;
    logic       mio_en, r_w, ben, halted;
  } obs_t;
  typedef struct {
    obs_t o;
    logic drive;
    logic mr;
  } step_t;
  step_t q[$];
  int total = 0;
  int bad = 0;
  logic ben_m = 1'b0;
  int legal[10] = '{1, 5, 9, 0, 12, 14, 2, 3, 6, 7};
  int illegal[6] = '{4, 8, 10, 11, 13, 15};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic obs_t sample();
    obs_t o;
    o.ld_mar = bus.ld_mar;  o.ld_mdr = bus.ld_mdr;  o.ld_ir = bus.ld_ir;
    o.ld_pc = bus.ld_pc;    o.ld_reg = bus.ld_reg;  o.ld_cc = bus.ld_cc;
    o.gate_pc = bus.gate_pc;  o.gate_mdr = bus.gate_mdr;
    o.gate_alu = bus.gate_alu;  o.gate_marmux = bus.gate_marmux;
    o.pcmux = bus.pcmux;  o.addr1mux = bus.addr1mux;  o.addr2mux = bus.addr2mux;
    o.sr1mux = bus.sr1mux;  o.aluk = bus.aluk;  o.mio_en = bus.mio_en;
    o.r_w = bus.r_w;  o.ben = bus.ben;  o.halted = bus.halted;
    return o;
  endfunction
  function automatic obs_t blank();
    obs_t o;
    o = '0;
    o.ben = ben_m;
    return o;
  endfunction
  function automatic void add(input obs_t o, input logic drive, input logic mr);
    step_t s;
    s.o = o;
    s.drive = drive;
    s.mr = mr;
    q.push_back(s);
  endfunction
  function automatic void add_wait(input obs_t o, input int w);
    for (int i = 0; i < w; i++) add(o, 1'b1, 1'b0);
    add(o, 1'b1, 1'b1);
  endfunction
  task automatic build(input logic [15:0] ir, input logic n, input logic z, input logic p,
                       input int wf, input int wm, output bit hlt);
    obs_t o;
    logic [3:0] op;
    op = ir[15:12];
    hlt = 1'b0;
    q.delete();
    o = blank(); o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; add(o, 1'b0, 1'b0);
    o = blank(); o.mio_en = 1; o.ld_mdr = 1; add_wait(o, wf);
    o = blank(); o.gate_mdr = 1; o.ld_ir = 1; add(o, 1'b0, 1'b0);
    add(blank(), 1'b0, 1'b0);
    ben_m = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    o = blank();
    case (op)
      4'h1, 4'h5, 4'h9: begin
        o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1;
        o.aluk = op == 4'h1 ? 2'd0 : op == 4'h5 ? 2'd1 : 2'd2;
        add(o, 1'b0, 1'b0);
      end
      4'h0: begin
        add(o, 1'b0, 1'b0);
        if (ben_m) begin
          o.pcmux = 2; o.addr2mux = 2; o.ld_pc = 1;
          add(o, 1'b0, 1'b0);
        end
      end
      4'hC: begin
        o.pcmux = 2; o.addr1mux = 1; o.ld_pc = 1;
        add(o, 1'b0, 1'b0);
      end
      4'hE: begin
        o.gate_marmux = 1; o.addr2mux = 2; o.ld_reg = 1;
        add(o, 1'b0, 1'b0);
      end
      4'h2, 4'h3, 4'h6, 4'h7: begin
        o.gate_marmux = 1; o.ld_mar = 1;
        o.addr1mux = op[2]; o.addr2mux = op[2] ? 2'd1 : 2'd2;
        add(o, 1'b0, 1'b0);
        if (!op[0]) begin
          o = blank(); o.mio_en = 1; o.ld_mdr = 1; add_wait(o, wm);
          o = blank(); o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; add(o, 1'b0, 1'b0);
        end else begin
          o = blank(); o.sr1mux = 1; o.aluk = 3; o.gate_alu = 1; o.ld_mdr = 1; add(o, 1'b0, 1'b0);
          o = blank(); o.mio_en = 1; o.r_w = 1; add_wait(o, wm);
        end
      end
      default: begin
        o.halted = 1;
        for (int i = 0; i < 20; i++) add(o, 1'b0, 1'b0);
        hlt = 1'b1;
      end
    endcase
  endtask
  task automatic do_instr(input string name, input logic [15:0] ir, input logic n,
                          input logic z, input logic p, input int wf, input int wm);
    bit hlt;
    bus.ir = ir; bus.n = n; bus.z = z; bus.p = p;
    build(ir, n, z, p, wf, wm, hlt);
    for (int i = 0; i < q.size(); i++) begin
      bus.mem_ready = q[i].drive ? q[i].mr : 1'($urandom);
      #1;
      check($sformatf("%s.c%0d", name, i), 32'(sample()), 32'(q[i].o));
      @(negedge clk);
    end
    if (hlt) begin
      #2 reset = 1'b0;
      #1 check({name, ".async_rst"}, 32'(sample()), 32'd0);
      ben_m = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
    end
  endtask
  initial begin
    logic [3:0] op;
    bus.ir = '0; bus.n = 0; bus.z = 0; bus.p = 0; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("reset%0d", i), 32'(sample()), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    do_instr("add", 16'h1042, 0, 0, 0, 0, 0);
    do_instr("brz_take", 16'h0405, 0, 1, 0, 0, 0);
    do_instr("brz_skip", 16'h0405, 0, 0, 1, 0, 0);
    do_instr("ldr_wait", 16'h6283, 0, 0, 0, 0, 3);
    do_instr("st", 16'h3003, 0, 0, 0, 0, 0);
    do_instr("illegal", 16'hD000, 0, 0, 0, 0, 0);
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 11) == 0 ? 4'(illegal[$urandom_range(0, 5)])
                                      : 4'(legal[$urandom_range(0, 9)]);
      do_instr($sformatf("rnd%0d", k), {op, 12'($urandom)}, 1'($urandom), 1'($urandom),
               1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
